// File: rtl/sar_search_ctrl_pkg.sv
// sar_search_ctrl_pkg: shared state encoding and width helper for the SAR search controller.
package sar_search_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    function automatic int iter_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search driving a magnitude comparator.
module sar_search_ctrl import sar_search_ctrl_pkg::*; #(
    parameter  int N      = 4,
    localparam int ITER_W = iter_w(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_lesser,
    input  logic              cmp_greater,
    input  logic              cmp_equal,
    output logic [N-1:0]      guess,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              hit,
    output logic [ITER_W-1:0] iters,
    output logic              err
);
    localparam int IDX_W = $clog2(N);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [N-1:0]        r_guess, r_result;
    logic [ITER_W-1:0]   r_iters;
    logic                r_busy, r_done, r_hit, r_err;
    logic                w_flags_ok;
    logic [N-1:0]        w_upd, w_step;

    assign w_flags_ok = $onehot({cmp_lesser, cmp_greater, cmp_equal});
    assign w_upd      = cmp_lesser ? r_guess & ~(N'(1) << r_idx) : r_guess;
    // shifting the current bit mask right sets the next trial bit; it vanishes at idx 0
    assign w_step     = w_upd | (N'(1) << r_idx) >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_iters  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hit    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= SEARCH;
                        r_guess  <= N'(1) << (N - 1);
                        r_idx    <= IDX_W'(N - 1);
                        r_iters  <= '0;
                        r_busy   <= 1'b1;
                        r_result <= '0;
                        r_hit    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                SEARCH: begin
                    r_iters <= r_iters + ITER_W'(1);
                    if (!w_flags_ok || cmp_equal || r_idx == '0) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= !w_flags_ok;
                        r_hit    <= w_flags_ok && cmp_equal;
                        r_result <= (w_flags_ok && !cmp_equal) ? w_upd : r_guess;
                        r_guess  <= (w_flags_ok && !cmp_equal) ? w_upd : r_guess;
                    end else begin
                        r_guess <= w_step;
                        r_idx   <= r_idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign hit    = r_hit;
    assign iters  = r_iters;
    assign err    = r_err;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: randomized and directed checks of sar_search_ctrl against a bit-prefix search model.
module tb_sar_search_ctrl;
    localparam int N = 4;
    localparam int ITER_W = $clog2(N) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              inj = 1'b0;
    logic [N-1:0]      a_val = '0;
    logic              cmp_lesser, cmp_greater, cmp_equal;
    logic [N-1:0]      guess, result;
    logic              busy, done, hit, err;
    logic [ITER_W-1:0] iters;
    int                n_chk = 0;
    int                n_pass = 0;

    always #5 clk = ~clk;

    // combinational comparator partner; inj forces a non-one-hot flag set
    assign cmp_lesser  = (a_val < guess) || inj;
    assign cmp_greater = (a_val > guess) || inj;
    assign cmp_equal   = (a_val == guess) && !inj;

    sar_search_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmp_lesser(cmp_lesser), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
        .guess(guess), .busy(busy), .done(done), .result(result),
        .hit(hit), .iters(iters), .err(err)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // k-th trial: A's bits above the trial bit, plus the trial bit itself
    function automatic int model_guess(input int a, input int k);
        return (a & ~((1 << (N - k)) - 1)) | (1 << (N - 1 - k));
    endfunction

    task automatic run(input int a, input int inj_at);
        int ni, hx, res, k;
        bit ex;
        ni = N;
        hx = 0;
        for (int i = N - 1; i >= 0; i--)
            if (model_guess(a, i) == a) begin
                ni = i + 1;
                hx = 1;
            end
        ex = (inj_at >= 0) && (inj_at < ni);
        res = a;
        if (ex) begin
            ni = inj_at + 1;
            hx = 0;
            res = model_guess(a, inj_at);
        end
        a_val = N'(a);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_start", busy, 1);
        k = 0;
        while (!done && k <= N + 1) begin
            if (k < N) chk($sformatf("guess_a%0d_k%0d", a, k), guess, model_guess(a, k));
            inj = (k == inj_at);
            @(negedge clk) inj = 1'b0;
            k++;
        end
        chk("done_seen", done, 1);
        chk("latency", k, ni);
        chk("iters", iters, ni);
        chk("result", result, res);
        chk("hit", hit, hx);
        chk("err", err, ex);
        chk("busy_done", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("guess_hold", guess, res);
    endtask

    initial begin
        int ok, cnt;
        #1;
        chk("rst_guess", guess, 0);
        chk("rst_flags", {busy, done, hit, err}, 0);
        chk("rst_result", result, 0);
        chk("rst_iters", iters, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run(11, -1);
        run(8, -1);
        run(0, -1);
        run(15, -1);
        run(13, 1);
        // reset mid-search after two compares
        a_val = 4'd13;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {guess, busy, done, result, hit, iters, err}, 0);
        ok = 1;
        repeat (3) @(negedge clk) if (done) ok = 0;
        chk("mid_rst_nodone", ok, 1);
        rst_n = 1'b1;
        run(13, -1);
        repeat (20) run(int'($urandom_range(0, 15)), $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : -1);
        // start held high: back-to-back searches with one IDLE cycle between
        a_val = 4'd5;
        @(negedge clk) start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cnt = 0;
            while (!done && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            chk("b2b_done", done, 1);
            chk("b2b_result", result, 5);
            chk("b2b_iters", iters, 4);
            @(negedge clk);
            chk("b2b_idle", {done, busy}, 0);
            @(negedge clk);
            chk("b2b_restart", busy, 1);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller that sits directly upstream of the team's N-bit magnitude comparator (comparator_nbit).
- Drives the comparator's B operand with a trial value each cycle and consumes its Lesser/Greater/Equal flags.
- Resolves the unknown unsigned value on the comparator's A operand, MSB first, one bit per clock.
- Early exit on Equal; reports result, hit flag, iteration count and a protocol error.

Parameters:
- N, default 4: operand width; must match the comparator width; N >= 2.
- ITER_W, localparam $clog2(N)+1: width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new search; sampled only in IDLE.
- cmp_lesser  input  1  comparator flag: A < guess.
- cmp_greater  input  1  comparator flag: A > guess.
- cmp_equal  input  1  comparator flag: A == guess.
- guess  output  N  trial value, wired to the comparator's B input.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse; result, hit, iters and err are valid.
- result  output  N  resolved value; held until the next accepted start.
- hit  output  1  search ended on cmp_equal.
- iters  output  ITER_W  number of compare cycles used (1..N).
- err  output  1  flags were not one-hot during a compare cycle.

Behaviour:
- Reset: asynchronous, active-low. All outputs clear to 0, state goes to IDLE, internal bit index clears. Reset mid-search abandons the search immediately; no done pulse.
- Registered outputs: all outputs are registered. The comparator is combinational, so the flags are valid in the same cycle as guess and are sampled at the next rising edge.

State machine (IDLE, SEARCH, DONE):
- IDLE:
  - start=1 at an edge -> SEARCH, guess = 1<<(N-1), idx = N-1, iters = 0, busy = 1.
  - result, hit, iters and err keep their previous values until that edge, then clear.
- SEARCH, each edge (one compare cycle):
  - iters increments.
  - Flags not exactly one-hot -> DONE, err = 1, hit = 0, result = guess.
  - cmp_equal -> DONE, hit = 1, result = guess.
  - Otherwise, if cmp_lesser, clear guess[idx]; if cmp_greater, keep it.
  - If idx > 0: set guess[idx-1], idx decrements, stay in SEARCH.
  - If idx == 0: DONE, hit = 0, result = the updated guess. For valid flags this equals A.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then -> IDLE.
  - start in DONE is ignored.
- start while busy is ignored.

Timing and values:
- Latency: done is high in the cycle beginning iters edges after the start-sampling edge. Worst case N+1 cycles from start to the done cycle inclusive.
- Width rules: guess and result are unsigned N-bit. iters never exceeds N. No arithmetic beyond single-bit set/clear.
- guess after DONE holds its final value until the next accepted start.
- The A operand must be stable from start until done. Behaviour for a changing A is undefined, but the FSM still terminates within N compare cycles.

Decomposition:
- Shared package: state enum typedef (IDLE, SEARCH, DONE) and the ITER_W helper function.
- No sub-module inside the block.
- The top-level bench instantiates this block with comparator_nbit as its partner.

Test Plan:
- N=4, A=11, start pulse -> guess sequence 8,12,10,11; done with result=11, hit=1, iters=4, err=0.
- N=4, A=8 -> cmp_equal on the first compare; done on the next cycle with result=8, hit=1, iters=1.
- N=4, A=0 -> guesses 8,4,2,1, all Lesser; result=0, hit=0, iters=4. Repeat with A=15: guesses 8,12,14,15, result=15, hit=1, iters=4.
- Flag injection: force cmp_lesser=cmp_greater=1 on the second compare -> done with err=1, hit=0, iters=2, result=12 (for A=13 after the first Greater).
- Reset asserted mid-search (after 2 compares) -> all outputs 0 immediately; no done pulse. A new start after release completes normally.
- start held high continuously, A=5 -> searches run back-to-back with exactly one IDLE cycle between the done pulse and the next SEARCH. start pulses during busy are ignored, and result=5 on every done.
